circular_fifo_rev2: RTL



---
 rtl/circular_fifo_rev2.sv | 117 +++++++++++
 1 files changed

// File: rtl/circular_fifo_rev2.sv
// circular_fifo_rev2
//   Single-clock circular FIFO with chip-select/enable handshake, programmable
//   almost-full/almost-empty thresholds, sticky overflow/underflow flags,
//   synchronous flush, and simultaneous read/write at the full/empty limits.
//
// Ports
//   clk              rising-edge clock
//   reset            synchronous, active-high reset
//   flush            synchronous clear of pointers, count and error flags
//   wr_cs, wr_en     write request when both high
//   data_in          write data
//   rd_cs, rd_en     read request when both high
//   data_out         registered read data, holds when no read is accepted
//   full, empty      occupancy == RAM_DEPTH / occupancy == 0
//   almost_full      occupancy >= AF_LEVEL
//   almost_empty     occupancy <= AE_LEVEL
//   overflow         sticky: write requested while blocked
//   underflow        sticky: read requested while empty
//   data_counter_out current occupancy, 0..RAM_DEPTH
//   wr_pointer_out   next write address
//   rd_pointer_out   next read address
module circular_fifo_rev2 #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 2,
  parameter int unsigned RAM_DEPTH  = 1 << ADDR_WIDTH,
  parameter int unsigned AF_LEVEL   = RAM_DEPTH - 1,
  parameter int unsigned AE_LEVEL   = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  wr_cs,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  rd_cs,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  overflow,
  output logic                  underflow,
  output logic [ADDR_WIDTH:0]   data_counter_out,
  output logic [ADDR_WIDTH-1:0] wr_pointer_out,
  output logic [ADDR_WIDTH-1:0] rd_pointer_out
);

  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(RAM_DEPTH);
  localparam logic [ADDR_WIDTH:0] AF_C    = (ADDR_WIDTH+1)'(AF_LEVEL);
  localparam logic [ADDR_WIDTH:0] AE_C    = (ADDR_WIDTH+1)'(AE_LEVEL);

  logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   count;

  logic wr_req, rd_req, wr_ok, rd_ok;

  always_comb begin
    full         = (count == DEPTH_C);
    empty        = (count == '0);
    almost_full  = (count >= AF_C);
    almost_empty = (count <= AE_C);
    wr_req       = wr_cs & wr_en;
    rd_req       = rd_cs & rd_en;
    rd_ok        = rd_req & ~empty;
    // A full FIFO still takes a write when a read frees a slot in the same cycle.
    wr_ok        = wr_req & (~full | rd_ok);
  end

  // Storage has no reset; reset and flush make old words unreachable via pointers.
  always_ff @(posedge clk) begin
    if (!reset && !flush && wr_ok)
      mem[wr_ptr] <= data_in;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_out  <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_ok)
        wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) begin
        data_out <= mem[rd_ptr];
        rd_ptr   <= rd_ptr + 1'b1;
      end
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (wr_req && !wr_ok)
        overflow <= 1'b1;
      if (rd_req && empty)
        underflow <= 1'b1;
    end
  end

  always_comb begin
    data_counter_out = count;
    wr_pointer_out   = wr_ptr;
    rd_pointer_out   = rd_ptr;
  end

endmodule
